// File: rtl/lcd_clock_ctrl_pkg.sv
// Shared definitions for the LCD clock controller: FSM encodings,
// the reset divisor and the stabilisation counter width helper.
package lcd_clock_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam logic [7:0] DIV_RST_DEF = 8'd4;

  // Width of the stabilisation counter; it only has to reach LOCK_CYCLES-1.
  function automatic int stab_w(input int lock_cycles);
    return (lock_cycles < 2) ? 1 : $clog2(lock_cycles);
  endfunction

endpackage

// File: rtl/lcd_clock_ctrl_if.sv
// Configuration and status bundle of the LCD clock controller.
// master: the host / downstream consumer; slave: the controller itself.
interface lcd_clock_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 8
);
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic                    div_load_i;
  logic                    clr_lost_i;
  logic [NUM_CH-1:0]       ce_o;
  logic [NUM_CH-1:0]       clk_div_o;
  logic                    rst_sync_n_o;
  logic                    lock_lost_o;
  logic [1:0]              state_o;

  modport master (
    output div_i, div_load_i, clr_lost_i,
    input  ce_o, clk_div_o, rst_sync_n_o, lock_lost_o, state_o
  );

  modport slave (
    input  div_i, div_load_i, clr_lost_i,
    output ce_o, clk_div_o, rst_sync_n_o, lock_lost_o, state_o
  );
endinterface

// File: rtl/lcd_clock_div_ch.sv
// One divider channel: counter, active/pending divisor and registered
// ce / divided-clock outputs. Outputs are computed from next-state values so
// they line up with the controller's state flop (start and stop together
// with rst_sync_n_o). A new divisor only takes effect at terminal count, so
// no runt period is ever produced.
module lcd_clock_div_ch
  import lcd_clock_pkg::*;
#(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             i_run,
  input  logic             i_run_nxt,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ce,
  output logic             o_clk_div
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_pend;
  logic             r_ce;
  logic             r_clk_div;

  logic             w_tc;
  logic             w_apply;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W:0]   w_half;
  logic             w_ce_nxt;
  logic             w_clk_div_nxt;

  // Terminal count, pending->active hand-over and next output values.
  always_comb begin
    w_tc      = i_run && (r_div_act != '0) && (r_cnt == r_div_act - DIV_W'(1));
    w_apply   = r_pend && (w_tc || !i_run || (r_div_act == '0));
    w_div_nxt = w_apply ? r_div_pend : r_div_act;
    if (!i_run || !i_run_nxt || w_tc || (r_div_act == '0)) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end
    // High phase is ceil(D/2) counts, so odd divisors lean high.
    w_half        = ({1'b0, w_div_nxt} + (DIV_W+1)'(1)) >> 1;
    w_ce_nxt      = i_run_nxt && (w_div_nxt != '0) &&
                    (w_cnt_nxt == w_div_nxt - DIV_W'(1));
    w_clk_div_nxt = i_run_nxt && (w_div_nxt != '0) &&
                    ({1'b0, w_cnt_nxt} < w_half);
  end

  // Channel state; a load arriving on the apply edge stays pending.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt      <= '0;
      r_div_act  <= DIV_RST;
      r_div_pend <= DIV_RST;
      r_pend     <= 1'b0;
      r_ce       <= 1'b0;
      r_clk_div  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_ce      <= w_ce_nxt;
      r_clk_div <= w_clk_div_nxt;
      if (w_apply) r_div_act <= r_div_pend;
      if (i_load) begin
        r_div_pend <= i_div;
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_ce      = r_ce;
  assign o_clk_div = r_clk_div;

endmodule

// File: rtl/lcd_clock_ctrl.sv
// LCD clock-domain controller: lock synchroniser, reset sequencing FSM,
// sticky lock-lost flag and NUM_CH programmable clock-enable channels.
//
//   state        | meaning
//   ST_WAIT_LOCK | downstream held in reset, waiting for synced lock
//   ST_STABILIZE | lock seen, counting LOCK_CYCLES stable cycles
//   ST_RUN       | reset released, divider channels running
module lcd_clock_ctrl
  import lcd_clock_pkg::*;
#(
  parameter int               NUM_CH      = 3,
  parameter int               DIV_W       = 8,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [DIV_W-1:0] DIV_RST     = DIV_W'(DIV_RST_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pll_lock_i,
  lcd_clock_ctrl_if.slave  bus
);

  localparam int                STAB_W    = stab_w(LOCK_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_CYCLES - 1);

  logic              r_lock_meta;
  logic              r_lock_sync;
  logic              r_lock_s;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STAB_W-1:0] w_stab_cnt_nxt;
  logic              r_lock_lost;
  logic              w_lost_set;
  logic              w_run;
  logic              w_run_nxt;
  logic [NUM_CH-1:0] w_ce;
  logic [NUM_CH-1:0] w_clk_div;

  // Two-flop synchroniser plus a retiming stage: lock_s rises two edges
  // after the edge that first samples pll_lock_i high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock_i;
      r_lock_sync <= r_lock_meta;
      r_lock_s    <= r_lock_sync;
    end
  end

  // Next-state, stabilisation count and lock-loss detection.
  always_comb begin
    w_state_nxt    = r_state;
    w_stab_cnt_nxt = r_stab_cnt;
    w_lost_set     = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_stab_cnt_nxt = '0;
        if (r_lock_s) w_state_nxt = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        if (!r_lock_s) begin
          w_state_nxt    = ST_WAIT_LOCK;
          w_stab_cnt_nxt = '0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_lost_set  = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_WAIT_LOCK;
        w_stab_cnt_nxt = '0;
      end
    endcase
  end

  // State, counter and sticky flag registers; a new loss beats a clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_WAIT_LOCK;
      r_stab_cnt  <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
      if (w_lost_set)          r_lock_lost <= 1'b1;
      else if (bus.clr_lost_i) r_lock_lost <= 1'b0;
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_run_nxt = (w_state_nxt == ST_RUN);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    lcd_clock_div_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .i_run     (w_run),
      .i_run_nxt (w_run_nxt),
      .i_load    (bus.div_load_i),
      .i_div     (bus.div_i[k*DIV_W +: DIV_W]),
      .o_ce      (w_ce[k]),
      .o_clk_div (w_clk_div[k])
    );
  end

  assign bus.ce_o         = w_ce;
  assign bus.clk_div_o    = w_clk_div;
  assign bus.rst_sync_n_o = w_run;
  assign bus.lock_lost_o  = r_lock_lost;
  assign bus.state_o      = r_state;

endmodule

// File: tb/tb_lcd_clock_ctrl.sv
// Directed bench for lcd_clock_ctrl with LOCK_CYCLES=16 and three channels.
// Edge numbers in comments count posedges from the one that first samples
// the new pll_lock_i value (edge 0); outputs are sampled 1 time unit later.
module tb_lcd_clock_ctrl;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;

  logic clk_i      = 1'b0;
  logic rst_n_i    = 1'b0;
  logic pll_lock_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  lcd_clock_ctrl_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  lcd_clock_ctrl #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DIV_RST     (8'd4)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .pll_lock_i (pll_lock_i),
    .bus        (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Raises lock and walks edges 0..19 of the release sequence.
  task automatic bring_up(input string tag);
    pll_lock_i = 1'b1;
    for (int e = 0; e <= 19; e++) begin
      tick();
      if (e == 2) begin
        n_cmp++;
        if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL %s_state_e2 got %0d exp 0", tag, bus.state_o); end
      end
      if (e == 3) begin
        n_cmp++;
        if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL %s_state_e3 got %0d exp 1", tag, bus.state_o); end
      end
      if (e == 18) begin
        n_cmp++;
        if (bus.rst_sync_n_o !== 1'b0) begin n_err++; $display("FAIL %s_rst_e18 got %b exp 0", tag, bus.rst_sync_n_o); end
      end
      if (e == 19) begin
        n_cmp++;
        if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL %s_state_e19 got %0d exp 2", tag, bus.state_o); end
        n_cmp++;
        if (bus.rst_sync_n_o !== 1'b1) begin n_err++; $display("FAIL %s_rst_e19 got %b exp 1", tag, bus.rst_sync_n_o); end
      end
    end
  endtask

  task automatic test_reset();
    bus.div_i      = {8'd4, 8'd4, 8'd4};
    bus.div_load_i = 1'b0;
    bus.clr_lost_i = 1'b0;
    rst_n_i        = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.ce_o !== 3'b000) begin n_err++; $display("FAIL reset_ce got %b exp 000", bus.ce_o); end
    n_cmp++; if (bus.clk_div_o !== 3'b000) begin n_err++; $display("FAIL reset_clk_div got %b exp 000", bus.clk_div_o); end
    n_cmp++; if (bus.rst_sync_n_o !== 1'b0) begin n_err++; $display("FAIL reset_rst_sync got %b exp 0", bus.rst_sync_n_o); end
    n_cmp++; if (bus.lock_lost_o !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost got %b exp 0", bus.lock_lost_o); end
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", bus.state_o); end
    rst_n_i = 1'b1;
    repeat (4) tick();
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL idle_state got %0d exp 0", bus.state_o); end
    n_cmp++; if (bus.rst_sync_n_o !== 1'b0) begin n_err++; $display("FAIL idle_rst_sync got %b exp 0", bus.rst_sync_n_o); end
  endtask

  // D=4 on all channels: clk_div 1,1,0,0 from RUN entry, ce on edge 22.
  task automatic test_bringup();
    logic [2:0] ce_x  [4] = '{3'b000, 3'b000, 3'b111, 3'b000};
    logic [2:0] clk_x [4] = '{3'b111, 3'b000, 3'b000, 3'b111};
    bring_up("bringup");
    n_cmp++; if (bus.clk_div_o !== 3'b111) begin n_err++; $display("FAIL bringup_clk_e19 got %b exp 111", bus.clk_div_o); end
    n_cmp++; if (bus.ce_o !== 3'b000) begin n_err++; $display("FAIL bringup_ce_e19 got %b exp 000", bus.ce_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.ce_o !== ce_x[i]) begin n_err++; $display("FAIL bringup_ce_e%0d got %b exp %b", 20 + i, bus.ce_o, ce_x[i]); end
      n_cmp++; if (bus.clk_div_o !== clk_x[i]) begin n_err++; $display("FAIL bringup_clk_e%0d got %b exp %b", 20 + i, bus.clk_div_o, clk_x[i]); end
    end
  endtask

  task automatic test_lock_loss();
    pll_lock_i = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL loss_state_e2 got %0d exp 2", bus.state_o); end
    n_cmp++; if (bus.rst_sync_n_o !== 1'b1) begin n_err++; $display("FAIL loss_rst_e2 got %b exp 1", bus.rst_sync_n_o); end
    bus.clr_lost_i = 1'b1;
    tick();
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL loss_state_e3 got %0d exp 0", bus.state_o); end
    n_cmp++; if (bus.rst_sync_n_o !== 1'b0) begin n_err++; $display("FAIL loss_rst_e3 got %b exp 0", bus.rst_sync_n_o); end
    n_cmp++; if (bus.ce_o !== 3'b000) begin n_err++; $display("FAIL loss_ce_e3 got %b exp 000", bus.ce_o); end
    n_cmp++; if (bus.clk_div_o !== 3'b000) begin n_err++; $display("FAIL loss_clk_e3 got %b exp 000", bus.clk_div_o); end
    n_cmp++; if (bus.lock_lost_o !== 1'b1) begin n_err++; $display("FAIL loss_set_wins got %b exp 1", bus.lock_lost_o); end
    bus.clr_lost_i = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.lock_lost_o !== 1'b1) begin n_err++; $display("FAIL loss_sticky got %b exp 1", bus.lock_lost_o); end
    pll_lock_i     = 1'b1;
    bus.clr_lost_i = 1'b1;
    tick();
    n_cmp++; if (bus.lock_lost_o !== 1'b0) begin n_err++; $display("FAIL loss_clear got %b exp 0", bus.lock_lost_o); end
    bus.clr_lost_i = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL relock_state_e2 got %0d exp 0", bus.state_o); end
    tick();
    n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL relock_state_e3 got %0d exp 1", bus.state_o); end
    pll_lock_i = 1'b0;
    repeat (6) tick();
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL relock_drop_state got %0d exp 0", bus.state_o); end
    n_cmp++; if (bus.lock_lost_o !== 1'b0) begin n_err++; $display("FAIL relock_drop_lost got %b exp 0", bus.lock_lost_o); end
  endtask

  task automatic test_lock_glitch();
    pll_lock_i = 1'b1;
    repeat (4) tick();
    n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL glitch_state_e3 got %0d exp 1", bus.state_o); end
    repeat (9) tick();
    pll_lock_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL glitch_state_e%0d got %0d exp 1", 13 + i, bus.state_o); end
    end
    tick();
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL glitch_state_e16 got %0d exp 0", bus.state_o); end
    n_cmp++; if (bus.lock_lost_o !== 1'b0) begin n_err++; $display("FAIL glitch_lost got %b exp 0", bus.lock_lost_o); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (bus.rst_sync_n_o !== 1'b0) begin n_err++; $display("FAIL glitch_rst_c%0d got %b exp 0", i, bus.rst_sync_n_o); end
    end
  endtask

  // Loads 5s at cnt=1, overwrites with {1,3,6} at cnt=2; applied at edge 23.
  // Then a load landing on ch0's terminal count (edge 35) waits one period.
  task automatic test_div_change();
    logic [2:0] ce_x  [14] = '{3'b000, 3'b111, 3'b100, 3'b100, 3'b110, 3'b100, 3'b100,
                               3'b111, 3'b100, 3'b100, 3'b110, 3'b100, 3'b100, 3'b111};
    logic [2:0] clk_x [14] = '{3'b000, 3'b000, 3'b111, 3'b111, 3'b101, 3'b110, 3'b110,
                               3'b100, 3'b111, 3'b111, 3'b101, 3'b110, 3'b110, 3'b100};
    logic       ce0_x  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       clk0_x [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bring_up("divchg");
    tick();
    bus.div_i      = {8'd5, 8'd5, 8'd5};
    bus.div_load_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) bus.div_i = {8'd1, 8'd3, 8'd6};
      if (i == 1) bus.div_load_i = 1'b0;
      n_cmp++; if (bus.ce_o !== ce_x[i]) begin n_err++; $display("FAIL divchg_ce_e%0d got %b exp %b", 21 + i, bus.ce_o, ce_x[i]); end
      n_cmp++; if (bus.clk_div_o !== clk_x[i]) begin n_err++; $display("FAIL divchg_clk_e%0d got %b exp %b", 21 + i, bus.clk_div_o, clk_x[i]); end
    end
    bus.div_i      = {8'd1, 8'd3, 8'd2};
    bus.div_load_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.div_load_i = 1'b0;
      n_cmp++; if (bus.ce_o[0] !== ce0_x[i]) begin n_err++; $display("FAIL tcload_ce0_e%0d got %b exp %b", 35 + i, bus.ce_o[0], ce0_x[i]); end
      n_cmp++; if (bus.clk_div_o[0] !== clk0_x[i]) begin n_err++; $display("FAIL tcload_clk0_e%0d got %b exp %b", 35 + i, bus.clk_div_o[0], clk0_x[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] ce_x  [4] = '{3'b000, 3'b000, 3'b111, 3'b000};
    logic [2:0] clk_x [4] = '{3'b111, 3'b000, 3'b000, 3'b111};
    #3;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL arst_state got %0d exp 0", bus.state_o); end
    n_cmp++; if (bus.rst_sync_n_o !== 1'b0) begin n_err++; $display("FAIL arst_rst_sync got %b exp 0", bus.rst_sync_n_o); end
    n_cmp++; if (bus.clk_div_o !== 3'b000) begin n_err++; $display("FAIL arst_clk got %b exp 000", bus.clk_div_o); end
    n_cmp++; if (bus.ce_o !== 3'b000) begin n_err++; $display("FAIL arst_ce got %b exp 000", bus.ce_o); end
    n_cmp++; if (bus.lock_lost_o !== 1'b0) begin n_err++; $display("FAIL arst_lost got %b exp 0", bus.lock_lost_o); end
    tick();
    rst_n_i = 1'b1;
    bring_up("arst");
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.ce_o !== ce_x[i]) begin n_err++; $display("FAIL arst_ce_e%0d got %b exp %b", 20 + i, bus.ce_o, ce_x[i]); end
      n_cmp++; if (bus.clk_div_o !== clk_x[i]) begin n_err++; $display("FAIL arst_clk_e%0d got %b exp %b", 20 + i, bus.clk_div_o, clk_x[i]); end
    end
  endtask

  // Divisors {ch2=3, ch1=1, ch0=0} loaded while waiting for lock.
  task automatic test_corner_div();
    logic [2:0] ce_x  [6] = '{3'b010, 3'b010, 3'b110, 3'b010, 3'b010, 3'b110};
    logic [2:0] clk_x [6] = '{3'b110, 3'b110, 3'b010, 3'b110, 3'b110, 3'b010};
    pll_lock_i = 1'b0;
    rst_n_i    = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    bus.div_i      = {8'd3, 8'd1, 8'd0};
    bus.div_load_i = 1'b1;
    tick();
    bus.div_load_i = 1'b0;
    tick();
    bring_up("corner");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_cmp++; if (bus.ce_o !== ce_x[i]) begin n_err++; $display("FAIL corner_ce_e%0d got %b exp %b", 19 + i, bus.ce_o, ce_x[i]); end
      n_cmp++; if (bus.clk_div_o !== clk_x[i]) begin n_err++; $display("FAIL corner_clk_e%0d got %b exp %b", 19 + i, bus.clk_div_o, clk_x[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_lock_glitch();
    test_div_change();
    test_async_reset();
    test_corner_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

endmodule
